// File: rtl/palette_pattern_gen_if.sv
// Pixel stream between the VGA timing generator, the pattern generator and the DAC stage.
// The master drives coordinates and valid; the slave returns the colour and its aligned valid.
interface palette_pattern_gen_if #(
  parameter int X_W = 10,
  parameter int Y_W = 10
);
  logic           valid_in;
  logic [X_W-1:0] x;
  logic [Y_W-1:0] y;
  logic [7:0]     memRGB;
  logic           valid_out;

  modport master (output valid_in, x, y, input memRGB, valid_out);
  modport slave  (input valid_in, x, y, output memRGB, valid_out);
endinterface

// File: rtl/palette_pattern_gen.sv
// Maps a VGA pixel coordinate to an RGB332 colour through a two-stage pipeline.
// The pattern is chosen per frame and can scroll the palette once every FRAME_DIV frames.
//
// state (mode_q) | meaning
// PAT_GRID       | palette grid, idx = COLS*y1 + x1
// PAT_GRAD       | horizontal gradient, idx = x1
// PAT_SCROLL     | grid plus scroll offset, offset advances on frame edges
// PAT_CHECK      | black/white checkerboard of blocks
module palette_pattern_gen #(
  parameter int X_W         = 10,
  parameter int Y_W         = 10,
  parameter int BLOCK_SHIFT = 5,
  parameter int COLS        = 20,
  parameter int SCROLL_STEP = 1,
  parameter int FRAME_DIV   = 1
) (
  input  logic                 CLK_IN,
  input  logic                 RST_N,
  input  logic                 FRAME_CLOCK,
  input  logic [1:0]           mode,
  palette_pattern_gen_if.slave pix
);

  typedef enum logic [1:0] {
    PAT_GRID   = 2'd0,
    PAT_GRAD   = 2'd1,
    PAT_SCROLL = 2'd2,
    PAT_CHECK  = 2'd3
  } pat_t;

  localparam logic [7:0] COLS8    = 8'(COLS);
  localparam logic [7:0] STEP8    = 8'(SCROLL_STEP);
  localparam logic [7:0] DIV_LAST = 8'(FRAME_DIV - 1);

  logic           frame_d;
  logic           fe;
  pat_t           mode_q, mode_nxt;
  logic [7:0]     div_q, div_nxt;
  logic [7:0]     off_q, off_nxt;

  logic [X_W-1:0] x1;
  logic [Y_W-1:0] y1;
  logic           v1;
  logic [7:0]     rgb_q, rgb_nxt;
  logic           v2;

  logic [7:0]     grid_idx;
  logic [7:0]     idx;

  assign fe = FRAME_CLOCK & ~frame_d;

  // Mode, divider and offset state register
  always_ff @(posedge CLK_IN or negedge RST_N) begin
    if (!RST_N) begin
      frame_d <= 1'b0;
      mode_q  <= PAT_GRID;
      div_q   <= 8'd0;
      off_q   <= 8'd0;
    end else begin
      frame_d <= FRAME_CLOCK;
      mode_q  <= mode_nxt;
      div_q   <= div_nxt;
      off_q   <= off_nxt;
    end
  end

  // A mode change on a frame edge restarts the scroll instead of stepping it
  always_comb begin
    mode_nxt = mode_q;
    div_nxt  = div_q;
    off_nxt  = off_q;
    if (fe) begin
      mode_nxt = pat_t'(mode);
      if (pat_t'(mode) != mode_q) begin
        div_nxt = 8'd0;
        off_nxt = 8'd0;
      end else if (mode_q == PAT_SCROLL) begin
        if (div_q == DIV_LAST) begin
          div_nxt = 8'd0;
          off_nxt = off_q + STEP8;
        end else begin
          div_nxt = div_q + 8'd1;
        end
      end
    end
  end

  always_comb begin
    grid_idx = (COLS8 * 8'(y1)) + 8'(x1);
    idx      = 8'd0;
    rgb_nxt  = 8'd0;
    case (mode_q)
      PAT_GRID:   idx = grid_idx;
      PAT_GRAD:   idx = 8'(x1);
      PAT_SCROLL: idx = grid_idx + off_q;
      default:    idx = 8'd0;
    endcase
    if (v1) begin
      if (mode_q == PAT_CHECK)
        rgb_nxt = (x1[0] ^ y1[0]) ? 8'hFF : 8'h00;
      else
        rgb_nxt = {idx[2:0], idx[5:3], idx[7:6]};
    end
  end

  always_ff @(posedge CLK_IN or negedge RST_N) begin
    if (!RST_N) begin
      x1    <= '0;
      y1    <= '0;
      v1    <= 1'b0;
      rgb_q <= 8'd0;
      v2    <= 1'b0;
    end else begin
      x1    <= pix.x >> BLOCK_SHIFT;
      y1    <= pix.y >> BLOCK_SHIFT;
      v1    <= pix.valid_in;
      rgb_q <= rgb_nxt;
      v2    <= v1;
    end
  end

  assign pix.memRGB    = rgb_q;
  assign pix.valid_out = v2;

endmodule

// File: tb/tb_palette_pattern_gen.sv
// Directed bench for palette_pattern_gen: three instances (default, FRAME_DIV=2,
// SCROLL_STEP=255) share one stimulus stream and are compared against hand-computed colours.
module tb_palette_pattern_gen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_clk = 1'b0;
  logic [1:0] mode_s = 2'd0;
  logic       vin = 1'b0;
  logic [9:0] xs = '0;
  logic [9:0] ys = '0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  palette_pattern_gen_if #(.X_W(10), .Y_W(10)) if_a ();
  palette_pattern_gen_if #(.X_W(10), .Y_W(10)) if_b ();
  palette_pattern_gen_if #(.X_W(10), .Y_W(10)) if_c ();

  assign if_a.valid_in = vin;
  assign if_a.x        = xs;
  assign if_a.y        = ys;
  assign if_b.valid_in = vin;
  assign if_b.x        = xs;
  assign if_b.y        = ys;
  assign if_c.valid_in = vin;
  assign if_c.x        = xs;
  assign if_c.y        = ys;

  palette_pattern_gen dut_a (
    .CLK_IN(clk), .RST_N(rst_n), .FRAME_CLOCK(frame_clk), .mode(mode_s), .pix(if_a)
  );
  palette_pattern_gen #(.FRAME_DIV(2)) dut_b (
    .CLK_IN(clk), .RST_N(rst_n), .FRAME_CLOCK(frame_clk), .mode(mode_s), .pix(if_b)
  );
  palette_pattern_gen #(.SCROLL_STEP(255)) dut_c (
    .CLK_IN(clk), .RST_N(rst_n), .FRAME_CLOCK(frame_clk), .mode(mode_s), .pix(if_c)
  );

  typedef struct {
    logic [9:0] x;
    logic [9:0] y;
    logic       v;
    logic [7:0] rgb;
    logic       vo;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input logic [9:0] px, input logic [9:0] py, input logic pv);
    xs  = px;
    ys  = py;
    vin = pv;
    tick();
    tick();
  endtask

  task automatic frame_pulse();
    frame_clk = 1'b1;
    tick();
    frame_clk = 1'b0;
    tick();
  endtask

  initial begin
    vecs[0] = '{x: 10'd0,   y: 10'd0,   v: 1'b1, rgb: 8'h00, vo: 1'b1};
    vecs[1] = '{x: 10'd32,  y: 10'd0,   v: 1'b1, rgb: 8'h20, vo: 1'b1};
    vecs[2] = '{x: 10'd0,   y: 10'd32,  v: 1'b1, rgb: 8'h88, vo: 1'b1};
    vecs[3] = '{x: 10'd639, y: 10'd479, v: 1'b1, rgb: 8'h74, vo: 1'b1};
    vecs[4] = '{x: 10'd32,  y: 10'd0,   v: 1'b0, rgb: 8'h00, vo: 1'b0};

    #2;
    check("reset_rgb_a", if_a.memRGB, 8'h00);
    check("reset_vo_a", {7'd0, if_a.valid_out}, 8'h00);
    check("reset_rgb_c", if_c.memRGB, 8'h00);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Mode 0 grid vectors
    for (int i = 0; i < 5; i++) begin
      apply(vecs[i].x, vecs[i].y, vecs[i].v);
      check($sformatf("grid_rgb_%0d", i), if_a.memRGB, vecs[i].rgb);
      check($sformatf("grid_vo_%0d", i), {7'd0, if_a.valid_out}, {7'd0, vecs[i].vo});
    end

    // Two-cycle latency of valid
    apply(10'd32, 10'd0, 1'b0);
    vin = 1'b1;
    tick();
    check("lat_vo_cycle1", {7'd0, if_a.valid_out}, 8'h00);
    tick();
    check("lat_vo_cycle2", {7'd0, if_a.valid_out}, 8'h01);
    check("lat_rgb_cycle2", if_a.memRGB, 8'h20);

    // Mode change only takes effect at a frame edge
    mode_s = 2'd3;
    apply(10'd32, 10'd0, 1'b1);
    check("latch_midframe", if_a.memRGB, 8'h20);
    frame_pulse();
    apply(10'd32, 10'd0, 1'b1);
    check("checker_1_0", if_a.memRGB, 8'hFF);
    apply(10'd32, 10'd32, 1'b1);
    check("checker_1_1", if_a.memRGB, 8'h00);
    apply(10'd32, 10'd0, 1'b0);
    check("checker_blank", if_a.memRGB, 8'h00);
    check("checker_blank_vo", {7'd0, if_a.valid_out}, 8'h00);

    // Scroll: latch mode 2, then further edges
    mode_s = 2'd2;
    frame_pulse();
    apply(10'd0, 10'd0, 1'b1);
    check("scroll_latch_a", if_a.memRGB, 8'h00);
    check("scroll_latch_c", if_c.memRGB, 8'h00);
    frame_pulse();
    frame_pulse();
    apply(10'd0, 10'd0, 1'b1);
    check("scroll2_a", if_a.memRGB, 8'h40);
    check("scroll_wrap_c", if_c.memRGB, 8'hDF);
    frame_pulse();
    apply(10'd0, 10'd0, 1'b1);
    check("scroll3_a", if_a.memRGB, 8'h60);
    check("scroll3_div2_b", if_b.memRGB, 8'h20);

    // Held-high frame marker is a single edge
    frame_clk = 1'b1;
    repeat (10) tick();
    frame_clk = 1'b0;
    tick();
    apply(10'd0, 10'd0, 1'b1);
    check("hold_a", if_a.memRGB, 8'h80);
    check("hold_div2_b", if_b.memRGB, 8'h40);
    check("hold_c", if_c.memRGB, 8'h9F);
    frame_pulse();
    apply(10'd0, 10'd0, 1'b1);
    check("scroll5_a", if_a.memRGB, 8'hA0);

    // Asynchronous reset mid-line
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async_rst_rgb", if_a.memRGB, 8'h00);
    check("async_rst_vo", {7'd0, if_a.valid_out}, 8'h00);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_vo_cycle1", {7'd0, if_a.valid_out}, 8'h00);
    tick();
    check("post_rst_vo_cycle2", {7'd0, if_a.valid_out}, 8'h01);
    check("post_rst_rgb_0_0", if_a.memRGB, 8'h00);
    apply(10'd32, 10'd0, 1'b1);
    check("post_rst_rgb_32_0", if_a.memRGB, 8'h20);

    // Gradient mode ignores y
    mode_s = 2'd1;
    frame_pulse();
    apply(10'd64, 10'd479, 1'b1);
    check("gradient_2", if_a.memRGB, 8'h40);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
